ex_div_unit: RTL and testbench

EX_DIV_UNIT -- requirements
Module: ex_div_unit

---
 rtl/ex_div_if.sv | 26 ++
 rtl/ex_div_unit.sv | 154 +++++++++++++++
 tb/tb_ex_div_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
interface ex_div_if #(
    parameter int DIV_W = 32
);
    logic             start_i;
    logic             signed_i;
    logic [DIV_W-1:0] dividend_i;
    logic [DIV_W-1:0] divisor_i;
    logic             flush_i;
    logic             stallreq_o;
    logic             done_o;
    logic [DIV_W-1:0] quotient_o;
    logic [DIV_W-1:0] remainder_o;

    // Pipeline side: issues requests, observes stall and results.
    modport master (
        output start_i, signed_i, dividend_i, divisor_i, flush_i,
        input  stallreq_o, done_o, quotient_o, remainder_o
    );

    // Divider side.
    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i, flush_i,
        output stallreq_o, done_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// signed operation by magnitude division followed by sign fix-up.
module ex_div_unit #(
    parameter int DIV_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    ex_div_if.slave   bus
);
    localparam int CNT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two's-complement negation.
    function automatic logic [DIV_W-1:0] neg2(input logic [DIV_W-1:0] x);
        return {DIV_W{1'b0}} - x;
    endfunction

    // Magnitude of x when treated as signed; raw value otherwise.
    function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x, input logic is_signed);
        if (is_signed && x[DIV_W-1]) begin
            return neg2(x);
        end else begin
            return x;
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] quo_q, quo_d;        // dividend shifting out, quotient shifting in
    logic [DIV_W-1:0] rem_q, rem_d;        // partial remainder
    logic [DIV_W-1:0] dvs_q, dvs_d;        // divisor magnitude
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [DIV_W-1:0] quo_out_q, quo_out_d;
    logic [DIV_W-1:0] rem_out_q, rem_out_d;

    logic [DIV_W:0]   partial_s;
    logic [DIV_W:0]   diff_s;

    // Shift-subtract datapath for the current iteration.
    always_comb begin
        partial_s = {rem_q, quo_q[DIV_W-1]};
        diff_s    = partial_s - {1'b0, dvs_q};
    end

    // Next-state, operand latching and result fix-up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        case (state_q)
            S_IDLE: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else if (bus.start_i) begin
                    if (bus.divisor_i == {DIV_W{1'b0}}) begin
                        quo_out_d = {DIV_W{1'b1}};
                        rem_out_d = bus.dividend_i;
                        state_d   = S_DONE;
                    end else begin
                        quo_d   = mag(bus.dividend_i, bus.signed_i);
                        dvs_d   = mag(bus.divisor_i, bus.signed_i);
                        rem_d   = {DIV_W{1'b0}};
                        qneg_d  = bus.signed_i & (bus.dividend_i[DIV_W-1] ^ bus.divisor_i[DIV_W-1]);
                        rneg_d  = bus.signed_i & bus.dividend_i[DIV_W-1];
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    // Partial remainder never exceeds the divisor, so DIV_W bits hold it.
                    if (!diff_s[DIV_W]) begin
                        rem_d = diff_s[DIV_W-1:0];
                        quo_d = {quo_q[DIV_W-2:0], 1'b1};
                    end else begin
                        rem_d = partial_s[DIV_W-1:0];
                        quo_d = {quo_q[DIV_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    quo_out_d = qneg_q ? neg2(quo_q) : quo_q;
                    rem_out_d = rneg_q ? neg2(rem_q) : rem_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            quo_q     <= {DIV_W{1'b0}};
            rem_q     <= {DIV_W{1'b0}};
            dvs_q     <= {DIV_W{1'b0}};
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            quo_out_q <= {DIV_W{1'b0}};
            rem_out_q <= {DIV_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
        end
    end

    // Stall releases during DONE so the EX stage advances on the edge that ends it.
    assign bus.stallreq_o  = bus.start_i & (state_q != S_DONE);
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.quotient_o  = quo_out_q;
    assign bus.remainder_o = rem_out_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed corner cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_ex_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ex_div_if #(.DIV_W(32)) bus ();

    ex_div_unit #(.DIV_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit signed arithmetic truncates toward zero, remainder takes dividend sign.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drive one request, keep start high until done, and report results and timing.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit scramble,
                         output logic [31:0] q, output logic [31:0] r, output int lat,
                         output int stalls, output logic stall_at_done);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = s;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk);
        lat = -1; stalls = 0; q = 32'hx; r = 32'hx; stall_at_done = 1'bx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat = i; q = bus.quotient_o; r = bus.remainder_o; stall_at_done = bus.stallreq_o;
                break;
            end
            if (bus.stallreq_o === 1'b1) stalls++;
            if (scramble) begin
                bus.dividend_i = $urandom;
                bus.divisor_i  = $urandom;
                bus.signed_i   = 1'($urandom);
            end
        end
        bus.start_i = 1'b0;
    endtask

    // Run one operation and compare everything against the model.
    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input bit scramble);
        logic [31:0] q, r, eq, er;
        int lat, stalls, elat;
        logic sd;
        ref_div(a, b, s, eq, er);
        elat = (b == 32'd0) ? 0 : 33;
        do_op(a, b, s, scramble, q, r, lat, stalls, sd);
        n_checks++;
        if (lat !== elat) $display("FAIL %s latency: got %0d, expected %0d", name, lat, elat);
        else n_pass++;
        n_checks++;
        if (q !== eq) $display("FAIL %s quotient (%h/%h s=%0b): got %h, expected %h", name, a, b, s, q, eq);
        else n_pass++;
        n_checks++;
        if (r !== er) $display("FAIL %s remainder (%h/%h s=%0b): got %h, expected %h", name, a, b, s, r, er);
        else n_pass++;
        n_checks++;
        if (stalls !== elat) $display("FAIL %s stall cycles: got %0d, expected %0d", name, stalls, elat);
        else n_pass++;
        n_checks++;
        if (sd !== 1'b0) $display("FAIL %s stall at done: got %b, expected 0", name, sd);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.flush_i = 1'b0;
        bus.dividend_i = 32'd0; bus.divisor_i = 32'd0;
        #12;
        n_checks++;
        if (bus.done_o !== 1'b0 || bus.quotient_o !== 32'd0 || bus.remainder_o !== 32'd0)
            $display("FAIL reset outputs: got done=%b q=%h r=%h, expected 0/0/0",
                     bus.done_o, bus.quotient_o, bus.remainder_o);
        else n_pass++;
        bus.start_i = 1'b1;
        #1;
        n_checks++;
        if (bus.stallreq_o !== 1'b1) $display("FAIL reset stall follows start: got %b, expected 1", bus.stallreq_o);
        else n_pass++;
        bus.start_i = 1'b0;
        #1;
        n_checks++;
        if (bus.stallreq_o !== 1'b0) $display("FAIL reset stall idle: got %b, expected 0", bus.stallreq_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        check_op("unsigned 100/7", 32'd100, 32'd7, 1'b0, 1'b0);
        check_op("signed -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        check_op("div by zero 5/0", 32'd5, 32'd0, 1'b0, 1'b0);
        check_op("signed div by zero", 32'hFFFF_FF00, 32'd0, 1'b1, 1'b0);
        check_op("signed overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check_op("unsigned max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check_op("signed 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    endtask

    task automatic test_hold();
        logic [31:0] q0, r0;
        check_op("hold setup 1000/9", 32'd1000, 32'd9, 1'b0, 1'b0);
        q0 = 32'd111; r0 = 32'd1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.quotient_o !== q0 || bus.remainder_o !== r0 || bus.done_o !== 1'b0)
            $display("FAIL hold outputs: got q=%h r=%h done=%b, expected %h/%h/0",
                     bus.quotient_o, bus.remainder_o, bus.done_o, q0, r0);
        else n_pass++;
    endtask

    task automatic test_ignore_inputs();
        for (int k = 0; k < 3; k++) begin
            check_op("scrambled inputs", $urandom, $urandom_range(1, 1000), 1'($urandom), 1'b1);
        end
    endtask

    task automatic test_flush();
        int seen_done;
        check_op("flush setup 100/7", 32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.dividend_i = 32'd5000; bus.divisor_i = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) $display("FAIL flush mid-calc done: got %0d done cycles, expected 0", seen_done);
        else n_pass++;
        n_checks++;
        if (bus.quotient_o !== 32'd14 || bus.remainder_o !== 32'd2)
            $display("FAIL flush retains outputs: got q=%h r=%h, expected 0000000e/00000002",
                     bus.quotient_o, bus.remainder_o);
        else n_pass++;
        // Flush wins over a simultaneous start in IDLE.
        @(negedge clk);
        bus.start_i = 1'b1; bus.flush_i = 1'b1;
        bus.dividend_i = 32'd9; bus.divisor_i = 32'd0;
        @(negedge clk);
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) seen_done++;
        end
        n_checks++;
        if (seen_done != 0 || bus.quotient_o !== 32'd14)
            $display("FAIL flush beats start: got %0d done cycles q=%h, expected 0 and 0000000e",
                     seen_done, bus.quotient_o);
        else n_pass++;
        check_op("after flush 77/5", 32'd77, 32'd5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.dividend_i = 32'd4000; bus.divisor_i = 32'd7;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.done_o !== 1'b0 || bus.quotient_o !== 32'd0 || bus.remainder_o !== 32'd0)
            $display("FAIL reset mid-calc: got done=%b q=%h r=%h, expected 0/0/0",
                     bus.done_o, bus.quotient_o, bus.remainder_o);
        else n_pass++;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_op("after reset 100/7", 32'd100, 32'd7, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = $urandom;
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (k % 5 == 0) a = 32'h8000_0000;
            check_op("random", a, b, 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_hold();
        test_ignore_inputs();
        test_flush();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
